// File: rtl/mips_mem_arb_pkg.sv
// Shared types and defaults for the MIPS single-port memory arbiter.
package mips_mem_arb_pkg;

    // Waitrequest cycles tolerated per access before the access is abandoned.
    localparam int MAX_WAIT_DEFAULT = 16;

    // One CPU instruction is a FETCH -> DATA -> COMMIT round; HALT is terminal.
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        COMMIT = 2'd2,
        HALT   = 2'd3
    } state_t;

endpackage

// File: rtl/mips_mem_arb_wdog.sv
// Per-access stall counter. 'expired' is high once MAX_WAIT-1 stalled cycles
// have been seen, so a further stalled cycle is the one that hits the limit.
module mips_mem_arb_wdog #(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    logic [CW-1:0] count_q;

    // Stall counter: clear has priority, otherwise count stalled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (count_en) begin
            count_q <= count_q + CW'(1);
        end else begin
            count_q <= count_q;
        end
    end

    assign expired = (count_q == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares one single-port memory between the CPU fetch and data ports.
// Each instruction runs FETCH -> DATA -> COMMIT; clk_enable pulses in COMMIT.
module mips_mem_arbiter
    import mips_mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_active,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        clk_enable,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest,
    output logic        bus_error
);
    state_t      state_q;
    state_t      state_d;
    logic [31:0] instr_q;
    logic [31:0] data_q;
    logic        bus_error_q;

    logic        mem_read_s;
    logic        mem_write_s;
    logic        commit_s;
    logic        wait_en_s;
    logic        advance_s;
    logic        idle_s;
    logic        timeout_s;
    logic        expired_s;
    logic        instr_ld_s;
    logic        data_ld_s;
    logic        err_set_s;
    logic [31:0] load_val_s;

    mips_mem_arb_wdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (advance_s | idle_s),
        .count_en (wait_en_s),
        .expired  (expired_s)
    );

    // Next state, memory strobes and latch/error enables for the current state.
    always_comb begin
        state_d       = state_q;
        mem_address   = 32'h0000_0000;
        mem_writedata = 32'h0000_0000;
        mem_read_s    = 1'b0;
        mem_write_s   = 1'b0;
        commit_s      = 1'b0;
        wait_en_s     = 1'b0;
        advance_s     = 1'b0;
        idle_s        = 1'b0;
        timeout_s     = 1'b0;
        instr_ld_s    = 1'b0;
        data_ld_s     = 1'b0;
        err_set_s     = 1'b0;
        case (state_q)
            FETCH: begin
                mem_address = instr_address;
                mem_read_s  = 1'b1;
                wait_en_s   = mem_waitrequest;
                if (!mem_waitrequest || expired_s) begin
                    timeout_s  = mem_waitrequest;
                    instr_ld_s = 1'b1;
                    advance_s  = 1'b1;
                    state_d    = DATA;
                end else begin
                    state_d = FETCH;
                end
            end
            DATA: begin
                if (data_write) begin
                    // A simultaneous load request loses to the store and is flagged.
                    mem_address   = data_address;
                    mem_write_s   = 1'b1;
                    mem_writedata = data_writedata;
                    wait_en_s     = mem_waitrequest;
                    err_set_s     = data_read;
                    if (!mem_waitrequest || expired_s) begin
                        timeout_s = mem_waitrequest;
                        advance_s = 1'b1;
                        state_d   = COMMIT;
                    end else begin
                        state_d = DATA;
                    end
                end else if (data_read) begin
                    mem_address = data_address;
                    mem_read_s  = 1'b1;
                    wait_en_s   = mem_waitrequest;
                    if (!mem_waitrequest || expired_s) begin
                        timeout_s = mem_waitrequest;
                        data_ld_s = 1'b1;
                        advance_s = 1'b1;
                        state_d   = COMMIT;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    advance_s = 1'b1;
                    state_d   = COMMIT;
                end
            end
            COMMIT: begin
                commit_s = 1'b1;
                idle_s   = 1'b1;
                if (cpu_active) begin
                    state_d = FETCH;
                end else begin
                    state_d = HALT;
                end
            end
            HALT: begin
                idle_s  = 1'b1;
                state_d = HALT;
            end
            default: begin
                idle_s  = 1'b1;
                state_d = FETCH;
            end
        endcase
        // An abandoned read returns zero rather than whatever the bus shows.
        if (timeout_s) begin
            load_val_s = 32'h0000_0000;
        end else begin
            load_val_s = mem_readdata;
        end
        err_set_s = err_set_s | timeout_s;
    end

    // State register, latched read words and sticky bus error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            instr_q     <= 32'h0000_0000;
            data_q      <= 32'h0000_0000;
            bus_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (instr_ld_s) begin
                instr_q <= load_val_s;
            end
            if (data_ld_s) begin
                data_q <= load_val_s;
            end
            if (err_set_s) begin
                bus_error_q <= 1'b1;
            end
        end
    end

    // Strobes and commit are suppressed while reset is held so an
    // interrupted access stops immediately and never commits.
    assign mem_read       = mem_read_s  & ~reset;
    assign mem_write      = mem_write_s & ~reset;
    assign clk_enable     = commit_s    & ~reset;
    assign instr_readdata = instr_q;
    assign data_readdata  = data_q;
    assign bus_error      = bus_error_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: a vector table of zero-wait
// instructions followed by hand-written multi-cycle corner sequences.
module tb_mips_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_active;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        clk_enable;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;
    logic        bus_error;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;

    // Instruction ROM at 0xBFC0_0000 and data RAM at 0x0, word indexed.
    logic [31:0] rom [16];
    logic [31:0] ram [16] = '{1: 32'h1234_5678, 2: 32'hAAAA_5555, default: 32'h0};

    typedef struct {
        logic [31:0] iaddr;
        logic        rd;
        logic        wr;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic [31:0] exp_instr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [4];

    mips_mem_arbiter #(.MAX_WAIT(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .cpu_active      (cpu_active),
        .instr_address   (instr_address),
        .instr_readdata  (instr_readdata),
        .data_address    (data_address),
        .data_read       (data_read),
        .data_write      (data_write),
        .data_writedata  (data_writedata),
        .data_readdata   (data_readdata),
        .clk_enable      (clk_enable),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_readdata    (mem_readdata),
        .mem_waitrequest (mem_waitrequest),
        .bus_error       (bus_error)
    );

    always #5 clk = ~clk;

    // Memory read port model.
    always_comb begin
        if (mem_address[31:28] == 4'hB) mem_readdata = rom[mem_address[5:2]];
        else                            mem_readdata = ram[mem_address[5:2]];
    end

    // Memory write port model; counts accepted writes.
    always @(posedge clk) begin
        if (mem_write && !mem_waitrequest) begin
            ram[mem_address[5:2]] <= mem_writedata;
            wr_count <= wr_count + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int wc0, mw_cyc, rd_cyc, err_cyc, commit_cyc, act_cyc;

        rom[0] = 32'h8C02_0004;  // lw $2,4($0)
        rom[1] = 32'hAC03_0008;  // sw $3,8($0)
        rom[2] = 32'h0000_0000;  // nop
        rom[3] = 32'h8C04_0008;  // lw $4,8($0)
        for (int k = 4; k < 16; k++) rom[k] = 32'h0;

        vecs[0] = '{32'hBFC0_0000, 1'b1, 1'b0, 32'h4, 32'h0,         32'h8C02_0004, 32'h1234_5678};
        vecs[1] = '{32'hBFC0_0004, 1'b0, 1'b1, 32'h8, 32'hCAFE_F00D, 32'hAC03_0008, 32'h1234_5678};
        vecs[2] = '{32'hBFC0_0008, 1'b0, 1'b0, 32'h0, 32'h0,         32'h0000_0000, 32'h1234_5678};
        vecs[3] = '{32'hBFC0_000C, 1'b1, 1'b0, 32'h8, 32'h0,         32'h8C04_0008, 32'hCAFE_F00D};

        reset = 1'b1; cpu_active = 1'b1; instr_address = 32'h0; data_address = 32'h0;
        data_read = 1'b0; data_write = 1'b0; data_writedata = 32'h0; mem_waitrequest = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_instr", instr_readdata, 32'h0);
        check("rst_data", data_readdata, 32'h0);
        check("rst_berr", {31'h0, bus_error}, 32'h0);
        check("rst_clken", {31'h0, clk_enable}, 32'h0);
        check("rst_mrd", {31'h0, mem_read}, 32'h0);
        check("rst_mwr", {31'h0, mem_write}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Table: zero-wait instructions, commit on every third cycle.
        for (int i = 0; i < 4; i++) begin
            instr_address  = vecs[i].iaddr;
            data_read      = vecs[i].rd;
            data_write     = vecs[i].wr;
            data_address   = vecs[i].daddr;
            data_writedata = vecs[i].wdata;
            @(negedge clk);
            check("c1_mrd", {31'h0, mem_read}, 32'h1);
            check("c1_mwr", {31'h0, mem_write}, 32'h0);
            check("c1_addr", mem_address, vecs[i].iaddr);
            check("c1_clken", {31'h0, clk_enable}, 32'h0);
            @(posedge clk); #1;
            @(negedge clk);
            check("c2_mrd", {31'h0, mem_read}, {31'h0, vecs[i].rd & ~vecs[i].wr});
            check("c2_mwr", {31'h0, mem_write}, {31'h0, vecs[i].wr});
            if (vecs[i].rd || vecs[i].wr) check("c2_addr", mem_address, vecs[i].daddr);
            if (vecs[i].wr) check("c2_wdata", mem_writedata, vecs[i].wdata);
            check("c2_clken", {31'h0, clk_enable}, 32'h0);
            check("c2_instr", instr_readdata, vecs[i].exp_instr);
            @(posedge clk); #1;
            @(negedge clk);
            check("c3_clken", {31'h0, clk_enable}, 32'h1);
            check("c3_strobes", {30'h0, mem_read, mem_write}, 32'h0);
            check("c3_data", data_readdata, vecs[i].exp_data);
            check("c3_berr", {31'h0, bus_error}, 32'h0);
            @(posedge clk); #1;
        end

        // Store with three stalled cycles in DATA.
        wc0 = wr_count; mw_cyc = 0; commit_cyc = 0;
        instr_address = 32'hBFC0_0004; data_read = 1'b0; data_write = 1'b1;
        data_address = 32'h8; data_writedata = 32'h0BAD_BEEF;
        for (int c = 1; c <= 8 && commit_cyc == 0; c++) begin
            mem_waitrequest = (c >= 2 && c <= 4);
            @(negedge clk);
            if (mem_write) mw_cyc++;
            if (clk_enable) commit_cyc = c;
            @(posedge clk); #1;
        end
        mem_waitrequest = 1'b0;
        check("st_mw_cycles", mw_cyc, 4);
        check("st_commit_cyc", commit_cyc, 6);
        check("st_writes", wr_count - wc0, 1);
        check("st_ram2", ram[2], 32'h0BAD_BEEF);
        check("st_berr", {31'h0, bus_error}, 32'h0);

        // Load and store requested together: store wins, error flagged.
        wc0 = wr_count; mw_cyc = 0; rd_cyc = 0; commit_cyc = 0;
        instr_address = 32'hBFC0_0008; data_read = 1'b1; data_write = 1'b1;
        data_address = 32'hC; data_writedata = 32'h55AA_55AA;
        for (int c = 1; c <= 6 && commit_cyc == 0; c++) begin
            @(negedge clk);
            if (mem_write) mw_cyc++;
            if (mem_read) rd_cyc++;
            if (clk_enable) commit_cyc = c;
            @(posedge clk); #1;
        end
        check("cf_mw_cycles", mw_cyc, 1);
        check("cf_rd_cycles", rd_cyc, 1);
        check("cf_commit_cyc", commit_cyc, 3);
        check("cf_writes", wr_count - wc0, 1);
        check("cf_ram3", ram[3], 32'h55AA_55AA);
        check("cf_data", data_readdata, 32'hCAFE_F00D);
        check("cf_berr", {31'h0, bus_error}, 32'h1);

        // Reset during a stalled DATA read.
        instr_address = 32'hBFC0_0000; data_read = 1'b1; data_write = 1'b0; data_address = 32'h4;
        @(negedge clk);
        @(posedge clk); #1;
        mem_waitrequest = 1'b1;
        @(negedge clk);
        check("rm_data_rd", {31'h0, mem_read}, 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rm_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        check("rm_clken", {31'h0, clk_enable}, 32'h0);
        check("rm_berr", {31'h0, bus_error}, 32'h0);
        check("rm_instr", instr_readdata, 32'h0);
        check("rm_data", data_readdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0; data_read = 1'b0; cpu_active = 1'b0;

        // Fetch stuck in waitrequest: abandoned after 16 cycles, then commit and halt.
        rd_cyc = 0; err_cyc = 0; commit_cyc = 0;
        for (int c = 1; c <= 30 && commit_cyc == 0; c++) begin
            @(negedge clk);
            if (c == 1) check("to_fetch_addr", mem_address, 32'hBFC0_0000);
            if (mem_read) rd_cyc++;
            if (bus_error && err_cyc == 0) err_cyc = c;
            if (clk_enable) commit_cyc = c;
            @(posedge clk); #1;
        end
        check("to_rd_cycles", rd_cyc, 16);
        check("to_err_cyc", err_cyc, 17);
        check("to_commit_cyc", commit_cyc, 18);
        check("to_instr", instr_readdata, 32'h0);

        // HALT: nothing happens for 50 cycles.
        mem_waitrequest = 1'b0; act_cyc = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (mem_read || mem_write || clk_enable) act_cyc++;
            @(posedge clk); #1;
        end
        check("halt_activity", act_cyc, 0);
        check("halt_berr_sticky", {31'h0, bus_error}, 32'h1);

        // Reset leaves HALT and restarts at FETCH.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; cpu_active = 1'b1;
        instr_address = 32'hBFC0_000C; data_read = 1'b1; data_address = 32'hC;
        @(negedge clk);
        check("rs_mrd", {31'h0, mem_read}, 32'h1);
        check("rs_addr", mem_address, 32'hBFC0_000C);
        check("rs_berr", {31'h0, bus_error}, 32'h0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("rs_clken", {31'h0, clk_enable}, 32'h1);
        check("rs_data", data_readdata, 32'h55AA_55AA);
        check("rs_instr", instr_readdata, 32'h8C04_0008);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_mem_arbiter.md
MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 16: waitrequest cycles tolerated per access before bus_error.
REQ-002 Ports: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Ports: reset  input  1  synchronous, active-high reset.
REQ-004 Ports: cpu_active  input  1  CPU active flag; low means halted.
REQ-005 Ports: instr_address  input  32  CPU fetch address.
REQ-006 Ports: instr_readdata  output  32  latched instruction word to CPU.
REQ-007 Ports: data_address  input  32  CPU data address.
REQ-008 Ports: data_read  input  1  CPU load request.
REQ-009 Ports: data_write  input  1  CPU store request.
REQ-010 Ports: data_writedata  input  32  CPU store data.
REQ-011 Ports: data_readdata  output  32  latched load data to CPU.
REQ-012 Ports: clk_enable  output  1  CPU clock enable; one-cycle commit pulse.
REQ-013 Ports: mem_address  output  32  shared single-port memory address.
REQ-014 Ports: mem_read  output  1  memory read strobe.
REQ-015 Ports: mem_write  output  1  memory write strobe.
REQ-016 Ports: mem_writedata  output  32  memory write data.
REQ-017 Ports: mem_readdata  input  32  memory read data, valid when mem_waitrequest low.
REQ-018 Ports: mem_waitrequest  input  1  high stalls current access.
REQ-019 Ports: bus_error  output  1  sticky: timeout or read+write conflict.

Function
REQ-020 The block SHALL share one memory port between CPU fetch and data ports via FSM states FETCH, DATA, COMMIT, HALT.
REQ-021 FETCH: drive mem_address=instr_address, mem_read=1; on cycle with mem_waitrequest=0, latch mem_readdata into instr_q, go DATA.
REQ-022 instr_readdata SHALL equal instr_q at all times; data_readdata SHALL equal data_q at all times.
REQ-023 DATA with neither data_read nor data_write: no strobes, go COMMIT next cycle.
REQ-024 DATA with data_read: mem_address=data_address, mem_read=1; on waitrequest low latch mem_readdata into data_q, go COMMIT.
REQ-025 DATA with data_write: mem_address=data_address, mem_write=1, mem_writedata=data_writedata; on waitrequest low go COMMIT; data_q unchanged.
REQ-026 data_read and data_write both high in DATA: write wins, bus_error set.
REQ-027 COMMIT: clk_enable=1 for exactly this cycle, no strobes; next state FETCH if cpu_active=1, else HALT.
REQ-028 clk_enable SHALL be 0 in every state except COMMIT.
REQ-029 HALT: no strobes, clk_enable=0, remain until reset.
REQ-030 Zero-wait memory: exactly 3 clk cycles per committed CPU instruction, for loads, stores and non-memory instructions alike.
REQ-031 Wait counter clears on entry to FETCH and DATA and increments per cycle with waitrequest high; at MAX_WAIT the access is abandoned: bus_error set, latch 32'h0 (reads), advance as if completed.
REQ-032 Strobes SHALL be driven combinationally from state and inputs; mem_write never asserted outside DATA.
REQ-033 bus_error SHALL be sticky until reset.

Reset
REQ-034 On reset: state FETCH, instr_q=0, data_q=0, wait counter 0, bus_error 0, clk_enable 0; reset mid-access drops strobes in the following cycle with no commit.

Structure
REQ-035 Package mips_mem_arb_pkg SHALL hold the state enum and MAX_WAIT default.
REQ-036 Wait counter/timeout SHALL be sub-module mips_mem_arb_wdog (clear, count enable, expired).

Verification
REQ-037 Zero-wait, instr 0x8C020004 (lw $2,4($0)) at 0xBFC00000, ram[1]=0x12345678 -> clk_enable pulses cycles 3,6,...; data_readdata=0x12345678 at first pulse.
REQ-038 Store sw to address 0x8, waitrequest high 3 cycles -> mem_write held 4 cycles, ram[2] updated once, commit at cycle 6.
REQ-039 waitrequest stuck high during FETCH, MAX_WAIT=16 -> bus_error=1 after 16 cycles, instr_readdata=0, commit follows.
REQ-040 data_read and data_write both high -> single write, no read strobe, bus_error=1.
REQ-041 cpu_active low at COMMIT -> HALT, no further strobes or clk_enable for 50 cycles; reset returns to FETCH.
REQ-042 Reset asserted during DATA with waitrequest high -> next cycle strobes 0, FETCH, outputs at reset values.
